// File: rtl/lif_step_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lif_step_scheduler : one shared leak/integrate/fire datapath swept over N
// neurons per step request; spikes leave as neuron-ID events (valid/ready).
// Revision: 1.0
// ============================================================================
module lif_step_scheduler #(
    parameter  int N          = 4,
    parameter  int W          = 8,
    parameter  int THRESH     = 200,
    parameter  int LEAK_SHIFT = 1,
    parameter  int REFRAC     = 2,
    localparam int IW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cur_we,
    input  logic [IW-1:0] cur_addr,
    input  logic [W-1:0]  cur_data,
    input  logic          step,
    output logic          busy,
    output logic          done,
    output logic          spk_valid,
    output logic [IW-1:0] spk_id,
    input  logic          spk_ready,
    output logic [7:0]    step_spikes,
    input  logic [IW-1:0] rd_addr,
    output logic [W-1:0]  rd_state
);

    localparam logic [W-1:0]  c_thresh = W'(THRESH);
    localparam logic [3:0]    c_refrac = 4'(REFRAC);
    localparam logic [IW-1:0] c_last   = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_idx;
    logic [7:0]     r_count;
    logic [W-1:0]   r_v    [N];
    logic [W-1:0]   r_cur  [N];
    logic [3:0]     r_refr [N];

    logic [W-1:0]   w_v_sel;
    logic [W-1:0]   w_cur_sel;
    logic [3:0]     w_refr_sel;
    logic [W-1:0]   w_leaked;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_sat;
    logic           w_fire;
    logic           w_last;

    // Operand select for the neuron under update; loop mux keeps every index in range.
    always_comb begin
        w_v_sel    = '0;
        w_cur_sel  = '0;
        w_refr_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) begin
                w_v_sel    = r_v[i];
                w_cur_sel  = r_cur[i];
                w_refr_sel = r_refr[i];
            end
        end
    end

    always_comb begin
        w_leaked = w_v_sel - (w_v_sel >> LEAK_SHIFT);
        w_sum    = {1'b0, w_leaked} + {1'b0, w_cur_sel};
        w_sat    = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
        w_fire   = (w_sat >= c_thresh);
        w_last   = (r_idx == c_last);
    end

    always_comb begin
        rd_state = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == IW'(i)) begin
                rd_state = r_v[i];
            end
        end
    end

    // Current registers are writable in every state; the sweep samples the
    // pre-edge value, so a same-cycle write lands for the next step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cur[i] <= '0;
            end
        end else if (cur_we) begin
            for (int i = 0; i < N; i++) begin
                if (cur_addr == IW'(i)) begin
                    r_cur[i] <= cur_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spk_valid   <= 1'b0;
            spk_id      <= '0;
            step_spikes <= '0;
            for (int i = 0; i < N; i++) begin
                r_v[i]    <= '0;
                r_refr[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx   <= '0;
                    r_count <= '0;
                    if (step) begin
                        r_state <= S_UPDATE;
                        busy    <= 1'b1;
                    end
                end

                S_UPDATE: begin
                    if (w_refr_sel != 4'd0) begin
                        r_refr[r_idx] <= w_refr_sel - 4'd1;
                        r_v[r_idx]    <= '0;
                    end else if (w_fire) begin
                        r_v[r_idx]    <= '0;
                        r_refr[r_idx] <= c_refrac;
                    end else begin
                        r_v[r_idx]    <= w_sat;
                    end

                    if ((w_refr_sel == 4'd0) && w_fire) begin
                        r_state   <= S_EMIT;
                        spk_valid <= 1'b1;
                        spk_id    <= r_idx;
                    end else if (w_last) begin
                        r_state     <= S_DONE;
                        done        <= 1'b1;
                        step_spikes <= r_count;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end

                S_EMIT: begin
                    if (spk_ready) begin
                        spk_valid <= 1'b0;
                        r_count   <= r_count + 8'd1;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            done        <= 1'b1;
                            step_spikes <= r_count + 8'd1;
                        end else begin
                            r_state <= S_UPDATE;
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_step_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_lif_step_scheduler : directed stimulus with a queued scoreboard of spike
// IDs and per-sweep spike counts, checked by an independent monitor.
// Revision: 1.0
// ============================================================================
module tb_lif_step_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cur_we = 1'b0;
    logic [IW-1:0] cur_addr = '0;
    logic [W-1:0]  cur_data = '0;
    logic          step = 1'b0;
    logic          busy;
    logic          done;
    logic          spk_valid;
    logic [IW-1:0] spk_id;
    logic          spk_ready = 1'b0;
    logic [7:0]    step_spikes;
    logic [IW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_state;

    lif_step_scheduler #(
        .N(N), .W(W), .THRESH(200), .LEAK_SHIFT(1), .REFRAC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
        .step(step), .busy(busy), .done(done),
        .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
        .step_spikes(step_spikes),
        .rd_addr(rd_addr), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ids[$];
    int exp_cnt[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: spike handshakes and sweep-end counts are checked against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (spk_valid && spk_ready) begin
                if (exp_ids.size() == 0) check("unexpected_spike_id", int'(spk_id), -1);
                else check("spk_id", int'(spk_id), exp_ids.pop_front());
            end
            if (done) begin
                if (exp_cnt.size() == 0) check("unexpected_done", int'(step_spikes), -1);
                else check("step_spikes", int'(step_spikes), exp_cnt.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cur(input int a, input int d);
        cur_we   = 1'b1;
        cur_addr = IW'(a);
        cur_data = W'(d);
        tick();
        cur_we   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        tick();
    endtask

    task automatic run_step(input string name);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(name);
    endtask

    task automatic peek(input int a, input int exp, input string name);
        rd_addr = IW'(a);
        #1;
        check(name, int'(rd_state), exp);
    endtask

    initial begin
        int t_done;

        // Power-on reset values
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_spk_valid", int'(spk_valid), 0);
        check("rst_step_spikes", int'(step_spikes), 0);
        tick();
        rst = 1'b0;

        // Reset asserted mid-sweep while an event is pending
        for (int i = 0; i < N; i++) write_cur(i, 255);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("pre_reset_spk_valid", int'(spk_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_spk_valid", int'(spk_valid), 0);
        check("mid_rst_spk_id", int'(spk_id), 0);
        check("mid_rst_step_spikes", int'(step_spikes), 0);
        for (int i = 0; i < N; i++) peek(i, 0, "mid_rst_v");
        tick();
        rst = 1'b0;
        spk_ready = 1'b1;

        // Integrate / fire / refractory on neuron 0
        write_cur(0, 150);
        exp_cnt.push_back(0);
        run_step("step1");
        peek(0, 150, "int_step1_v0");
        exp_ids.push_back(0); exp_cnt.push_back(1);
        run_step("step2");
        peek(0, 0, "int_step2_v0");
        exp_cnt.push_back(0);
        run_step("step3");
        peek(0, 0, "int_step3_v0");
        exp_cnt.push_back(0);
        run_step("step4");
        peek(0, 0, "int_step4_v0");
        exp_cnt.push_back(0);
        run_step("step5");
        peek(0, 150, "int_step5_v0");
        write_cur(0, 0);

        // Saturation on neuron 1 (v0 leaks 150 -> 75 -> 38 meanwhile)
        write_cur(1, 199);
        exp_cnt.push_back(0);
        run_step("sat_pre");
        peek(1, 199, "sat_pre_v1");
        peek(0, 75, "sat_pre_v0");
        write_cur(1, 255);
        exp_ids.push_back(1); exp_cnt.push_back(1);
        run_step("sat_fire");
        peek(1, 0, "sat_fire_v1");
        peek(0, 38, "sat_fire_v0");
        write_cur(1, 0);

        // Latency and ignored step while busy
        exp_cnt.push_back(0);
        t_done = 0;
        step = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) step = 1'b0;
            if (t == 2) step = 1'b1;
            if (t == 3) step = 1'b0;
            if (t == 1) check("lat_busy_c1", int'(busy), 1);
            if (done && t_done == 0) t_done = t;
            if (t == 6) check("lat_idle_after_done", int'(busy), 0);
        end
        check("lat_done_cycle", t_done, 5);
        exp_cnt.push_back(0);
        run_step("lat_next");
        peek(0, 10, "lat_next_v0");

        // Backpressure: every neuron fires, consumer stalls on the first event
        for (int i = 0; i < N; i++) write_cur(i, 255);
        spk_ready = 1'b0;
        for (int i = 0; i < N; i++) exp_ids.push_back(i);
        exp_cnt.push_back(4);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_spk_valid", int'(spk_valid), 1);
            check("bp_spk_id", int'(spk_id), 0);
            check("bp_busy", int'(busy), 1);
            tick();
        end
        spk_ready = 1'b1;
        wait_done("bp");
        for (int i = 0; i < N; i++) peek(i, 0, "bp_v");

        // Concurrent write to neuron 2 during its own update cycle
        for (int i = 0; i < N; i++) write_cur(i, 0);
        exp_cnt.push_back(0);
        run_step("cw_clear1");
        exp_cnt.push_back(0);
        run_step("cw_clear2");
        exp_cnt.push_back(0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        cur_we   = 1'b1;
        cur_addr = 2'd2;
        cur_data = 8'd100;
        tick();
        cur_we   = 1'b0;
        wait_done("cw");
        peek(2, 0, "cw_v2_same_step");
        exp_cnt.push_back(0);
        run_step("cw_next");
        peek(2, 100, "cw_v2_next_step");

        repeat (3) tick();
        check("ids_drained", exp_ids.size(), 0);
        check("counts_drained", exp_cnt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
